// File: rtl/mesh_term_injector.sv
// Injection stage for one mesh terminal: range-checks raw requests, formats them into
// mesh packets with a per-terminal sequence number, and queues them in a FWFT FIFO.
module mesh_term_injector #(
    parameter int ROWS       = 4,
    parameter int COLUMS     = 4,
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 8,
    parameter int term_row   = 0,
    parameter int term_col   = 1,
    parameter int SEQ_W      = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_vld,
    output logic                                 in_rdy,
    input  logic [3:0]                           in_dst_row,
    input  logic [3:0]                           in_dst_col,
    input  logic                                 in_mode,
    input  logic                                 in_bcst,
    input  logic [pckg_sz-17-SEQ_W-1:0]          in_payload,
    input  logic                                 popin,
    output logic                                 pndng_i_in,
    output logic [pckg_sz-1:0]                   data_out_i_in,
    output logic [$clog2(fifo_depth+1)-1:0]      fill_lvl,
    output logic [15:0]                          err_cnt,
    output logic [SEQ_W-1:0]                     seq_nxt
);

    localparam int PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int CW = $clog2(fifo_depth + 1);

    localparam logic [3:0] TROW    = 4'(term_row);
    localparam logic [3:0] TCOL    = 4'(term_col);
    localparam logic [3:0] ROW_MAX = 4'(ROWS);
    localparam logic [3:0] COL_MAX = 4'(COLUMS);
    localparam logic [3:0] ROW_P1  = 4'(ROWS + 1);
    localparam logic [3:0] COL_P1  = 4'(COLUMS + 1);

    logic [pckg_sz-1:0] r_mem [fifo_depth];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_cnt;
    logic [15:0]        r_err;
    logic [SEQ_W-1:0]   r_seq;
    logic [pckg_sz-1:0] r_dout;

    logic               w_full;
    logic               w_acc;
    logic               w_legal;
    logic               w_push;
    logic               w_rej;
    logic               w_pop;
    logic [3:0]         w_dst_row;
    logic [3:0]         w_dst_col;
    logic [pckg_sz-1:0] w_pkt;
    logic [PW-1:0]      w_rd_nxt;
    logic [CW-1:0]      w_cnt_nxt;
    logic [CW-1:0]      w_remain;
    logic [pckg_sz-1:0] w_head_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(fifo_depth - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_full = (r_cnt == CW'(fifo_depth));
    assign in_rdy = !reset && !w_full;
    assign w_acc  = in_vld && in_rdy;
    assign w_push = w_acc && (in_bcst || w_legal);
    assign w_rej  = w_acc && !in_bcst && !w_legal;
    assign w_pop  = popin && (r_cnt != '0);

    // Legal targets are the edge ports ringing the mesh, minus this terminal itself.
    always_comb begin
        w_legal = 1'b0;
        if (in_dst_row == 4'd0 || in_dst_row == ROW_P1)
            w_legal = (in_dst_col >= 4'd1) && (in_dst_col <= COL_MAX);
        else if (in_dst_row >= 4'd1 && in_dst_row <= ROW_MAX)
            w_legal = (in_dst_col == 4'd0) || (in_dst_col == COL_P1);
        if (in_dst_row == TROW && in_dst_col == TCOL)
            w_legal = 1'b0;
    end

    assign w_dst_row = in_bcst ? 4'hF : in_dst_row;
    assign w_dst_col = in_bcst ? 4'hF : in_dst_col;
    assign w_pkt     = {TROW, TCOL, w_dst_row, w_dst_col, in_mode, r_seq, in_payload};

    assign w_rd_nxt  = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    assign w_remain  = w_pop ? r_cnt - CW'(1) : r_cnt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop)
            w_cnt_nxt = r_cnt + CW'(1);
        else if (!w_push && w_pop)
            w_cnt_nxt = r_cnt - CW'(1);
    end

    // Head is registered so it can hold its last value once the FIFO drains.
    always_comb begin
        w_head_nxt = r_dout;
        if (w_remain != '0)
            w_head_nxt = r_mem[w_rd_nxt];
        else if (w_push)
            w_head_nxt = w_pkt;
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_pkt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_err    <= '0;
            r_seq    <= '0;
            r_dout   <= '0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_dout   <= w_head_nxt;
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
                r_seq    <= r_seq + SEQ_W'(1);
            end
            if (w_rej && r_err != 16'hFFFF)
                r_err <= r_err + 16'd1;
        end
    end

    assign pndng_i_in    = (r_cnt != '0);
    assign data_out_i_in = r_dout;
    assign fill_lvl      = r_cnt;
    assign err_cnt       = r_err;
    assign seq_nxt       = r_seq;

endmodule

// File: tb/tb_mesh_term_injector.sv
// Self-checking bench for mesh_term_injector: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_mesh_term_injector;

    localparam int D   = 8;
    localparam int PLW = 15;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_vld = 1'b0;
    logic           in_rdy;
    logic [3:0]     in_dst_row = '0;
    logic [3:0]     in_dst_col = '0;
    logic           in_mode = 1'b0;
    logic           in_bcst = 1'b0;
    logic [PLW-1:0] in_payload = '0;
    logic           popin = 1'b0;
    logic           pndng_i_in;
    logic [39:0]    data_out_i_in;
    logic [3:0]     fill_lvl;
    logic [15:0]    err_cnt;
    logic [7:0]     seq_nxt;

    always #5 clk = ~clk;

    mesh_term_injector #(
        .ROWS(4), .COLUMS(4), .pckg_sz(40), .fifo_depth(D),
        .term_row(0), .term_col(1), .SEQ_W(8)
    ) dut (
        .clk(clk), .reset(reset), .in_vld(in_vld), .in_rdy(in_rdy),
        .in_dst_row(in_dst_row), .in_dst_col(in_dst_col), .in_mode(in_mode),
        .in_bcst(in_bcst), .in_payload(in_payload), .popin(popin),
        .pndng_i_in(pndng_i_in), .data_out_i_in(data_out_i_in),
        .fill_lvl(fill_lvl), .err_cnt(err_cnt), .seq_nxt(seq_nxt)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [39:0] m_q[$];
    int          m_err = 0;
    int          m_seq = 0;
    logic [39:0] m_last = '0;
    bit          legal_map [16][16];
    int          legal_r[$];
    int          legal_c[$];

    typedef struct {
        bit          rst;
        bit          vld;
        logic [3:0]  row;
        logic [3:0]  col;
        bit          mode;
        bit          bcst;
        logic [14:0] pl;
        bit          pop;
        bit          e_rdy;
        bit          e_pnd;
        int          e_fill;
        int          e_err;
        int          e_seq;
        logic [39:0] e_data;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [39:0] fmt(input logic [3:0] r, input logic [3:0] c,
                                        input bit mode, input bit bcst, input int seq,
                                        input logic [14:0] pl);
        logic [3:0] dr;
        logic [3:0] dc;
        logic [7:0] s;
        dr = bcst ? 4'hF : r;
        dc = bcst ? 4'hF : c;
        s  = 8'(seq % 256);
        return {4'd0, 4'd1, dr, dc, mode, s, pl};
    endfunction

    task automatic apply(input bit rst, input bit vld, input logic [3:0] r, input logic [3:0] c,
                         input bit mode, input bit bcst, input logic [14:0] pl, input bit pop);
        bit rdy_pre;
        bit do_pop;
        reset = rst; in_vld = vld; in_dst_row = r; in_dst_col = c;
        in_mode = mode; in_bcst = bcst; in_payload = pl; popin = pop;
        @(posedge clk);
        if (rst) begin
            m_q.delete(); m_err = 0; m_seq = 0; m_last = '0;
        end else begin
            rdy_pre = (m_q.size() < D);
            do_pop  = pop && (m_q.size() > 0);
            if (do_pop) void'(m_q.pop_front());
            if (vld && rdy_pre) begin
                if (bcst || legal_map[r][c]) begin
                    m_q.push_back(fmt(r, c, mode, bcst, m_seq, pl));
                    m_seq = (m_seq + 1) % 256;
                end else if (m_err < 65535) begin
                    m_err++;
                end
            end
            if (m_q.size() > 0) m_last = m_q[0];
        end
        #1;
        chk("model_rdy",  64'(in_rdy),        64'(!rst && m_q.size() < D));
        chk("model_pnd",  64'(pndng_i_in),    64'(m_q.size() > 0));
        chk("model_fill", 64'(fill_lvl),      64'(m_q.size()));
        chk("model_err",  64'(err_cnt),       64'(m_err));
        chk("model_seq",  64'(seq_nxt),       64'(m_seq));
        chk("model_data", 64'(data_out_i_in), 64'(m_last));
    endtask

    task automatic push_legal(input bit pop);
        int k;
        k = $urandom_range(0, legal_r.size() - 1);
        apply(0, 1, 4'(legal_r[k]), 4'(legal_c[k]), 1'($urandom_range(0, 1)), 0,
              15'($urandom), pop);
    endtask

    initial begin
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) legal_map[r][c] = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            legal_map[0][c] = 1'b1;
            legal_map[5][c] = 1'b1;
        end
        for (int r = 1; r <= 4; r++) begin
            legal_map[r][0] = 1'b1;
            legal_map[r][5] = 1'b1;
        end
        legal_map[0][1] = 1'b0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                if (legal_map[r][c]) begin legal_r.push_back(r); legal_c.push_back(c); end

        //          rst vld row   col   m  b  payload    pop rdy pnd fill err seq data
        vt[0]  = '{1, 0, 4'd0, 4'd0, 0, 0, 15'h0000, 0,  0,  0,  0,  0,  0, 40'h0};
        vt[1]  = '{0, 0, 4'd0, 4'd0, 0, 0, 15'h0000, 0,  1,  0,  0,  0,  0, 40'h0};
        vt[2]  = '{0, 1, 4'd5, 4'd2, 0, 0, 15'h1234, 0,  1,  1,  1,  0,  1, 40'h0152001234};
        vt[3]  = '{0, 0, 4'd0, 4'd0, 0, 0, 15'h0000, 1,  1,  0,  0,  0,  1, 40'h0152001234};
        vt[4]  = '{1, 0, 4'd0, 4'd0, 0, 0, 15'h0000, 0,  0,  0,  0,  0,  0, 40'h0};
        vt[5]  = '{0, 1, 4'd2, 4'd2, 0, 0, 15'h0011, 0,  1,  0,  0,  1,  0, 40'h0};
        vt[6]  = '{0, 1, 4'd0, 4'd1, 0, 0, 15'h0022, 0,  1,  0,  0,  2,  0, 40'h0};
        vt[7]  = '{0, 1, 4'd5, 4'd5, 0, 0, 15'h0033, 0,  1,  0,  0,  3,  0, 40'h0};
        vt[8]  = '{0, 1, 4'd0, 4'd0, 0, 0, 15'h0044, 0,  1,  0,  0,  4,  0, 40'h0};
        vt[9]  = '{0, 1, 4'd2, 4'd2, 1, 1, 15'h7FFF, 0,  1,  1,  1,  4,  1, 40'h01FF807FFF};
        vt[10] = '{0, 1, 4'd4, 4'd5, 0, 0, 15'h0001, 1,  1,  1,  1,  4,  2, 40'h0145008001};
        vt[11] = '{0, 0, 4'd0, 4'd0, 0, 0, 15'h0000, 1,  1,  0,  0,  4,  2, 40'h0145008001};
        vt[12] = '{0, 1, 4'd0, 4'd4, 1, 0, 15'h0000, 0,  1,  1,  1,  4,  3, 40'h0104810000};
        vt[13] = '{0, 1, 4'd1, 4'd0, 0, 0, 15'h0ABC, 0,  1,  1,  2,  4,  4, 40'h0104810000};
        vt[14] = '{0, 0, 4'd0, 4'd0, 0, 0, 15'h0000, 1,  1,  1,  1,  4,  4, 40'h0110018ABC};
        vt[15] = '{0, 0, 4'd0, 4'd0, 0, 0, 15'h0000, 1,  1,  0,  0,  4,  4, 40'h0110018ABC};
        vt[16] = '{0, 0, 4'd0, 4'd0, 0, 0, 15'h0000, 1,  1,  0,  0,  4,  4, 40'h0110018ABC};

        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            apply(vt[i].rst, vt[i].vld, vt[i].row, vt[i].col, vt[i].mode, vt[i].bcst,
                  vt[i].pl, vt[i].pop);
            chk($sformatf("vec%0d_rdy", i),  64'(in_rdy),        64'(vt[i].e_rdy));
            chk($sformatf("vec%0d_pnd", i),  64'(pndng_i_in),    64'(vt[i].e_pnd));
            chk($sformatf("vec%0d_fill", i), 64'(fill_lvl),      64'(vt[i].e_fill));
            chk($sformatf("vec%0d_err", i),  64'(err_cnt),       64'(vt[i].e_err));
            chk($sformatf("vec%0d_seq", i),  64'(seq_nxt),       64'(vt[i].e_seq));
            chk($sformatf("vec%0d_data", i), 64'(data_out_i_in), 64'(vt[i].e_data));
        end

        // Fill to capacity, hold off a 9th request, then drain in order.
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < D; i++) push_legal(0);
        chk("full_fill", 64'(fill_lvl), 64'(8));
        chk("full_rdy",  64'(in_rdy),   64'(0));
        push_legal(0);
        chk("holdoff_fill", 64'(fill_lvl), 64'(8));
        chk("holdoff_seq",  64'(seq_nxt),  64'(8));
        chk("head_seq0",    64'(data_out_i_in[22:15]), 64'(0));
        push_legal(1);
        chk("holdoff_pop_fill", 64'(fill_lvl), 64'(7));
        chk("holdoff_pop_rdy",  64'(in_rdy),   64'(1));
        chk("holdoff_pop_seq",  64'(seq_nxt),  64'(8));
        push_legal(0);
        chk("ninth_fill", 64'(fill_lvl), 64'(8));
        chk("ninth_seq",  64'(seq_nxt),  64'(9));
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain_seq%0d", i), 64'(data_out_i_in[22:15]), 64'(i));
            apply(0, 0, 0, 0, 0, 0, 0, 1);
        end
        chk("drain_empty", 64'(pndng_i_in), 64'(0));

        // Steady push+pop with one entry preloaded; runs long enough to wrap seq.
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        push_legal(0);
        for (int k = 0; k < 270; k++) begin
            push_legal(1);
            chk("wrap_fill",     64'(fill_lvl),             64'(1));
            chk("wrap_head_seq", 64'(data_out_i_in[22:15]), 64'((k + 1) % 256));
            chk("wrap_seq_nxt",  64'(seq_nxt),              64'((k + 2) % 256));
        end

        // Reset mid-operation with buffered entries and a concurrent pop.
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 1, 4'd3, 4'd3, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) push_legal(0);
        chk("prerst_fill", 64'(fill_lvl), 64'(5));
        apply(1, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_fill", 64'(fill_lvl),   64'(0));
        chk("rst_pnd",  64'(pndng_i_in), 64'(0));
        chk("rst_err",  64'(err_cnt),    64'(0));
        chk("rst_seq",  64'(seq_nxt),    64'(0));
        chk("rst_rdy",  64'(in_rdy),     64'(0));
        chk("rst_data", 64'(data_out_i_in), 64'(0));
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        chk("postrst_rdy", 64'(in_rdy), 64'(1));

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            apply(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 6)), 4'($urandom_range(0, 6)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                  15'($urandom), ($urandom_range(0, 2) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mesh_term_injector.md
Name: mesh_term_injector

Overview:
Per-terminal injection stage that sits directly upstream of one mesh_gnrtr terminal input port and feeds it.
- Accepts raw requests (destination, mode, payload) from a traffic source over a valid/ready handshake.
- Range-checks the destination and formats each request into a pckg_sz-bit mesh packet with a per-terminal sequence number.
- Buffers packets in a first-word-fall-through FIFO and presents them to the mesh on pndng_i_in/data_out_i_in, popped by popin.

Parameters:
ROWS, 4, mesh rows.
COLUMS, 4, mesh columns.
pckg_sz, 40, packet width in bits.
fifo_depth, 8, FIFO entries; must be at least 2.
term_row, 0, row address of this terminal.
term_col, 1, column address of this terminal.
SEQ_W, 8, sequence-number width; must be at most pckg_sz-18.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
in_vld  in  1  request valid
in_rdy  out  1  injector can accept a request
in_dst_row  in  4  destination row
in_dst_col  in  4  destination column
in_mode  in  1  routing mode bit (0 = row-first, 1 = column-first)
in_bcst  in  1  broadcast request
in_payload  in  pckg_sz-17-SEQ_W  user payload
popin  in  1  mesh pops head entry
pndng_i_in  out  1  FIFO non-empty
data_out_i_in  out  pckg_sz  head packet (FWFT)
fill_lvl  out  $clog2(fifo_depth+1)  current occupancy
err_cnt  out  16  rejected-request counter, saturating
seq_nxt  out  SEQ_W  sequence number for the next accepted packet

Behaviour:
- Single clock domain.
- Reset (synchronous, active-high) clears FIFO pointers, fill_lvl, err_cnt and seq_nxt to 0. Outputs during and after reset: pndng_i_in=0, in_rdy=0 while reset=1 and 1 after, data_out_i_in=0.
- Reset asserted mid-operation discards all buffered packets; a popin in the same cycle is ignored.
- Packet format, MSB to LSB:
  - [pckg_sz-1:pckg_sz-8] nxt_jmp = {term_row[3:0], term_col[3:0]}
  - [pckg_sz-9:pckg_sz-12] dst_row
  - [pckg_sz-13:pckg_sz-16] dst_col
  - [pckg_sz-17] mode
  - [pckg_sz-18:pckg_sz-17-SEQ_W] seq
  - remaining low bits: payload
- Broadcast (in_bcst=1): dst_row = dst_col = 4'hF, mode = in_mode, in_dst_* ignored, range check skipped.
- Legal destinations, checked when in_bcst=0:
  - (0, 1..COLUMS), (ROWS+1, 1..COLUMS), (1..ROWS, 0), (1..ROWS, COLUMS+1)
  - excluding (term_row, term_col)
- Accept rule: a request is accepted on an edge where in_vld & in_rdy = 1. in_rdy = !full, combinational from registered count.
  - Legal or broadcast: packet written to the FIFO tail; seq_nxt increments, wrapping mod 2^SEQ_W.
  - Illegal: not written; err_cnt increments, saturating at 16'hFFFF; seq_nxt unchanged. The handshake still completes (request consumed).
- Latency: request accepted at edge N gives pndng_i_in=1 and data_out_i_in = formatted packet from edge N onward, i.e. visible in cycle N+1.
- Pop: on an edge with popin & pndng_i_in, the head advances. popin while empty is ignored, with no pointer or count change.
- Simultaneous legal push and pop: both occur and fill_lvl is unchanged.
- When full, in_rdy=0 even if popin=1 in the same cycle; there is no bypass. in_rdy returns to 1 in the cycle after the pop.
- Pointers wrap modulo fifo_depth. fill_lvl ranges 0..fifo_depth.
- data_out_i_in is held stable while pndng_i_in=1 and no pop occurs. It holds its last value when empty.

Test Plan:
- Reset then single legal request (dst 5,2; mode 0; payload 15'h1234) with term (0,1) -> next cycle pndng_i_in=1, data_out_i_in = {8'h01, 4'h5, 4'h2, 1'b0, 8'h00, 15'h1234}, seq_nxt=1; popin for 1 cycle -> pndng_i_in=0, fill_lvl=0.
- Illegal destinations (2,2), then self address (0,1) -> nothing enqueued, err_cnt=2, seq_nxt=0, in_rdy stays 1.
- 8 legal pushes with popin=0 -> fill_lvl=8, in_rdy=0; 9th request held off (in_vld high, not accepted); one pop -> in_rdy=1 next cycle, 9th accepted, entries drain in order with seq 0..8.
- Continuous push plus pop for 20 cycles with one preloaded entry -> fill_lvl stays 1, seq_nxt wraps correctly past 255 when preset near the limit, packet order preserved.
- Broadcast request with in_dst=(2,2) -> accepted, dst fields 4'hF, err_cnt unchanged.
- Reset asserted with 5 entries buffered and popin=1 -> next cycle fill_lvl=0, pndng_i_in=0, err_cnt=0, seq_nxt=0.
